rmt_dest_demux: RTL and testbench

- Sits directly downstream of the RMT match stage and consumes its single AXI-Stream output, including the 2-bit tdest.
- Steers each whole frame to one of M_COUNT function-engine output ports.
- Frames whose tdest is out of range are discarded.
- Each output has a registered skid buffer, which isolates the engines' backpressure timing from the match stage.
- Per-port frame counters are kept for the host CSR block.

---
 rtl/rmt_pkg.sv | 14 +
 rtl/axis_skid_buf.sv | 84 ++++++++
 rtl/rmt_dest_demux.sv | 127 ++++++++++++
 tb/tb_rmt_dest_demux.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_pkg.sv
// Shared RMT definitions: demux state encodings and destination codes common
// to the match stage and the destination demux.
package rmt_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_FWD  = 2'd1,
        STATE_DROP = 2'd2
    } state_t;

    localparam logic [1:0] RMT_DEST_DEFAULT = 2'd0;
    localparam logic [1:0] RMT_DEST_FUNC1   = 2'd1;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer with a registered ready, decoupling the
// downstream engine's backpressure from the upstream combinational path.
module axis_skid_buf #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    localparam int BEAT_WIDTH = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    logic [BEAT_WIDTH-1:0] in_beat;
    logic [BEAT_WIDTH-1:0] out_beat, out_beat_next;
    logic [BEAT_WIDTH-1:0] skid_beat, skid_beat_next;
    logic                  out_valid, out_valid_next;
    logic                  skid_valid, skid_valid_next;
    logic                  ready_reg;
    logic                  push, pop;

    assign in_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    assign push    = s_axis_tvalid && ready_reg;
    assign pop     = out_valid && m_axis_tready;

    // The skid entry only fills while the output entry is stalled, so a full
    // buffer always has ready low and never sees a push alongside a pop.
    always_comb begin
        out_valid_next  = out_valid;
        skid_valid_next = skid_valid;
        out_beat_next   = out_beat;
        skid_beat_next  = skid_beat;
        if (pop) begin
            if (skid_valid) begin
                out_beat_next   = skid_beat;
                skid_valid_next = 1'b0;
            end else begin
                out_valid_next = 1'b0;
            end
        end
        if (push) begin
            if (!out_valid_next) begin
                out_valid_next = 1'b1;
                out_beat_next  = in_beat;
            end else begin
                skid_valid_next = 1'b1;
                skid_beat_next  = in_beat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_beat   <= '0;
            skid_beat  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            out_valid  <= out_valid_next;
            skid_valid <= skid_valid_next;
            out_beat   <= out_beat_next;
            skid_beat  <= skid_beat_next;
            ready_reg  <= !skid_valid_next;
        end
    end

    assign s_axis_tready = ready_reg;
    assign m_axis_tvalid = out_valid;
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = out_beat;

endmodule

// File: rtl/rmt_dest_demux.sv
// Routes whole frames from the RMT match stage to per-engine skid buffers by
// first-beat tdest, discarding frames with an out-of-range destination.
module rmt_dest_demux
    import rmt_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 8,
    parameter int DEST_WIDTH = 2,
    parameter int M_COUNT    = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]           s_axis_tkeep,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [USER_WIDTH-1:0]           s_axis_tuser,
    input  logic [DEST_WIDTH-1:0]           s_axis_tdest,
    output logic [M_COUNT*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic [M_COUNT-1:0]              m_axis_tvalid,
    input  logic [M_COUNT-1:0]              m_axis_tready,
    output logic [M_COUNT-1:0]              m_axis_tlast,
    output logic [M_COUNT*USER_WIDTH-1:0]   m_axis_tuser,
    output logic [M_COUNT*CNT_WIDTH-1:0]    stat_fwd_frames,
    output logic [CNT_WIDTH-1:0]            stat_drop_frames
);

    state_t                state_reg;
    logic [DEST_WIDTH-1:0] dest_reg;
    logic [DEST_WIDTH-1:0] sel;
    logic                  sel_valid;
    logic                  sel_ready;
    logic                  active;
    logic                  xfer;
    logic [M_COUNT-1:0]    skid_ready;
    logic [M_COUNT-1:0]    push;
    logic [CNT_WIDTH-1:0]  fwd_cnt [M_COUNT];
    logic [CNT_WIDTH-1:0]  drop_cnt;

    // Ready comes only from state, tdest and the registered skid readies, never
    // from tvalid; 'active' keeps it low while reset is asserted.
    always_comb begin
        sel       = (state_reg == STATE_IDLE) ? s_axis_tdest : dest_reg;
        sel_valid = (state_reg != STATE_DROP) && (int'(sel) < M_COUNT);
        sel_ready = 1'b0;
        for (int p = 0; p < M_COUNT; p++) begin
            if (sel == DEST_WIDTH'(p)) sel_ready = skid_ready[p];
        end
        s_axis_tready = active && (sel_valid ? sel_ready : 1'b1);
        xfer          = s_axis_tvalid && s_axis_tready;
        push          = '0;
        for (int p = 0; p < M_COUNT; p++) begin
            push[p] = xfer && sel_valid && (sel == DEST_WIDTH'(p));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= STATE_IDLE;
            dest_reg  <= DEST_WIDTH'(RMT_DEST_DEFAULT);
            active    <= 1'b0;
        end else begin
            active <= 1'b1;
            if (xfer) begin
                case (state_reg)
                    STATE_IDLE: begin
                        if (sel_valid) begin
                            dest_reg <= s_axis_tdest;
                            if (!s_axis_tlast) state_reg <= STATE_FWD;
                        end else if (!s_axis_tlast) begin
                            state_reg <= STATE_DROP;
                        end
                    end
                    STATE_FWD, STATE_DROP: begin
                        if (s_axis_tlast) state_reg <= STATE_IDLE;
                    end
                    default: state_reg <= STATE_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < M_COUNT; p++) fwd_cnt[p] <= '0;
            drop_cnt <= '0;
        end else begin
            for (int p = 0; p < M_COUNT; p++) begin
                if (push[p] && s_axis_tlast) fwd_cnt[p] <= fwd_cnt[p] + CNT_WIDTH'(1);
            end
            if (xfer && (state_reg == STATE_IDLE) && !sel_valid) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign stat_drop_frames = drop_cnt;

    for (genvar p = 0; p < M_COUNT; p++) begin : g_port
        axis_skid_buf #(
            .DATA_WIDTH (DATA_WIDTH),
            .KEEP_WIDTH (KEEP_WIDTH),
            .USER_WIDTH (USER_WIDTH)
        ) u_skid (
            .clk           (clk),
            .rst_n         (rst_n),
            .s_axis_tdata  (s_axis_tdata),
            .s_axis_tkeep  (s_axis_tkeep),
            .s_axis_tvalid (push[p]),
            .s_axis_tready (skid_ready[p]),
            .s_axis_tlast  (s_axis_tlast),
            .s_axis_tuser  (s_axis_tuser),
            .m_axis_tdata  (m_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH]),
            .m_axis_tkeep  (m_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH]),
            .m_axis_tvalid (m_axis_tvalid[p]),
            .m_axis_tready (m_axis_tready[p]),
            .m_axis_tlast  (m_axis_tlast[p]),
            .m_axis_tuser  (m_axis_tuser[p*USER_WIDTH +: USER_WIDTH])
        );
        assign stat_fwd_frames[p*CNT_WIDTH +: CNT_WIDTH] = fwd_cnt[p];
    end

endmodule

// File: tb/tb_rmt_dest_demux.sv
// Scoreboard bench for rmt_dest_demux: expected beats are queued per port on
// input acceptance and popped as each port delivers.
module tb_rmt_dest_demux;
    import rmt_pkg::*;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   s_axis_tdata = '0;
    logic [KW-1:0]   s_axis_tkeep = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic            s_axis_tlast = 1'b0;
    logic [UW-1:0]   s_axis_tuser = '0;
    logic [1:0]      s_axis_tdest = '0;
    logic [2*DW-1:0] m_axis_tdata;
    logic [2*KW-1:0] m_axis_tkeep;
    logic [1:0]      m_axis_tvalid;
    logic [1:0]      m_axis_tready = 2'b11;
    logic [1:0]      m_axis_tlast;
    logic [2*UW-1:0] m_axis_tuser;
    logic [2*CW-1:0] stat_fwd_frames;
    logic [CW-1:0]   stat_drop_frames;

    int check_count = 0;
    int pass_count  = 0;
    int accepted    = 0;
    int delivered   = 0;

    beat_t      q0[$];
    beat_t      q1[$];
    beat_t      mon_exp;
    bit         mon_have;
    logic [CW-1:0] fwd_model [2];
    logic [CW-1:0] drop_model;

    rmt_dest_demux #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .USER_WIDTH (UW),
        .DEST_WIDTH (2),
        .M_COUNT    (2),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tdest     (s_axis_tdest),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .stat_fwd_frames  (stat_fwd_frames),
        .stat_drop_frames (stat_drop_frames)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Outputs are sampled on the falling edge; a beat seen valid and ready here
    // transfers on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                if (m_axis_tvalid[p] && m_axis_tready[p]) begin
                    mon_have = 1'b0;
                    if (p == 0 && q0.size() > 0) begin
                        mon_exp  = q0.pop_front();
                        mon_have = 1'b1;
                    end else if (p == 1 && q1.size() > 0) begin
                        mon_exp  = q1.pop_front();
                        mon_have = 1'b1;
                    end
                    check_output($sformatf("port%0d_beat_expected", p), 64'(mon_have), 64'd1);
                    if (mon_have) begin
                        check_output($sformatf("port%0d_data", p), m_axis_tdata[p*DW +: DW], mon_exp.data);
                        check_output($sformatf("port%0d_keep_user_last", p),
                                     64'({m_axis_tkeep[p*KW +: KW], m_axis_tuser[p*UW +: UW], m_axis_tlast[p]}),
                                     64'({mon_exp.keep, mon_exp.user, mon_exp.last}));
                    end
                    delivered++;
                end
            end
        end
    end

    task automatic drive_beat(input logic [1:0] dest, input beat_t b, output int waited, output bit ok);
        bit rdy;
        waited = 0;
        ok     = 1'b0;
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b.data;
        s_axis_tkeep  = b.keep;
        s_axis_tuser  = b.user;
        s_axis_tlast  = b.last;
        s_axis_tdest  = dest;
        forever begin
            #1 rdy = s_axis_tready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            waited++;
            if (waited > 200) begin
                check_output("accept_timeout", 64'(waited), 64'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    // Later beats carry tdest 0 so that any use of tdest past the first beat shows up.
    task automatic apply_stimulus(input logic [1:0] dest, input int n, input logic [7:0] keep,
                                  input int max_beats, input bit chk_lat, input bit chk_ready);
        beat_t b;
        int    waited;
        bit    ok;
        for (int i = 0; i < n && i < max_beats; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = keep;
            b.user = 8'($urandom);
            b.last = (i == n - 1);
            drive_beat((i == 0) ? dest : 2'd0, b, waited, ok);
            if (chk_ready) check_output("drop_ready_high", 64'(waited), 64'd0);
            if (ok) begin
                if (dest < 2'd2) begin
                    if (dest == 2'd0) q0.push_back(b);
                    else q1.push_back(b);
                    accepted++;
                    if (b.last) fwd_model[dest[0]] = fwd_model[dest[0]] + 1'b1;
                end else if (i == 0) begin
                    drop_model = drop_model + 1'b1;
                end
            end
            if (chk_lat && i == 0) begin
                @(negedge clk);
                s_axis_tvalid = 1'b0;
                check_output("first_beat_latency", 64'(m_axis_tvalid), 64'b10);
            end
        end
    endtask

    task automatic idle_and_drain(input string tag);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check_output({tag, "_q0_drained"}, 64'(q0.size()), 64'd0);
        check_output({tag, "_q1_drained"}, 64'(q1.size()), 64'd0);
        check_output({tag, "_fwd0"}, 64'(stat_fwd_frames[CW-1:0]), 64'(fwd_model[0]));
        check_output({tag, "_fwd1"}, 64'(stat_fwd_frames[2*CW-1:CW]), 64'(fwd_model[1]));
        check_output({tag, "_drop"}, 64'(stat_drop_frames), 64'(drop_model));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        fwd_model[0] = '0;
        fwd_model[1] = '0;
        drop_model   = '0;

        #3;
        check_output("reset_tready", 64'(s_axis_tready), 64'd0);
        check_output("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_output("reset_tdata", m_axis_tdata[63:0] | m_axis_tdata[127:64], 64'd0);
        check_output("reset_counters", 64'({stat_fwd_frames, stat_drop_frames}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("tready_after_release", 64'(s_axis_tready), 64'd1);

        $display("[TB] 3-beat frame to port 1");
        apply_stimulus(RMT_DEST_FUNC1, 3, 8'hFF, 3, 1'b1, 1'b0);
        idle_and_drain("t1");

        $display("[TB] single-beat frame to port 0 then 2-beat frame to port 1");
        apply_stimulus(RMT_DEST_DEFAULT, 1, 8'h3F, 1, 1'b0, 1'b0);
        apply_stimulus(RMT_DEST_FUNC1, 2, 8'hFF, 2, 1'b0, 1'b0);
        idle_and_drain("t2");

        $display("[TB] 4-beat frame to invalid dest 3");
        apply_stimulus(2'd3, 4, 8'hFF, 4, 1'b0, 1'b1);
        idle_and_drain("t3");

        $display("[TB] 10-beat frame to port 0 with backpressure");
        fork
            apply_stimulus(2'd0, 10, 8'hFF, 10, 1'b0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #2 m_axis_tready[0] = 1'b0;
                repeat (5) @(posedge clk);
                #2;
                check_output("stall_tready_low", 64'(s_axis_tready), 64'd0);
                check_output("stall_buffered", 64'(accepted - delivered), 64'd2);
                m_axis_tready[0] = 1'b1;
            end
        join
        idle_and_drain("t4");

        $display("[TB] reset during beat 3 of a 6-beat frame");
        apply_stimulus(2'd0, 6, 8'hFF, 2, 1'b0, 1'b0);
        @(negedge clk);
        s_axis_tdata  = {$urandom, $urandom};
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_output("midreset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_output("midreset_counters", 64'({stat_fwd_frames, stat_drop_frames}), 64'd0);
        s_axis_tvalid = 1'b0;
        q0.delete();
        q1.delete();
        fwd_model[0] = '0;
        fwd_model[1] = '0;
        drop_model   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(RMT_DEST_FUNC1, 2, 8'hFF, 2, 1'b0, 1'b0);
        idle_and_drain("t5");

        $display("[TB] 17 single-beat frames to port 0 for counter wrap");
        for (int f = 0; f < 17; f++) apply_stimulus(2'd0, 1, 8'h0F, 1, 1'b0, 1'b0);
        idle_and_drain("t6");
        check_output("wrap_fwd0", 64'(stat_fwd_frames[CW-1:0]), 64'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
